// File: rtl/gpr_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpr_wb_arbiter_pkg
// Brief    : Shared GPR writeback widths and request record.
// Revision : 1.0 - initial release
// ============================================================================
package gpr_wb_arbiter_pkg;

    localparam int XLEN    = 64;
    localparam int NREG    = 32;
    localparam int AW      = $clog2(NREG);
    localparam int NLOOKUP = 3;

    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/gpr_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : gpr_scoreboard
// Brief    : Pending-write vector for long-latency ops with set/clear and
//            three hazard lookup ports.
// Revision : 1.0 - initial release
// ============================================================================
module gpr_scoreboard
    import gpr_wb_arbiter_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        set_en,
    input  logic [AW-1:0]               set_idx,
    input  logic                        clr_en,
    input  logic [AW-1:0]               clr_idx,
    input  logic [NLOOKUP-1:0]          lk_en,
    input  logic [NLOOKUP-1:0][AW-1:0]  lk_idx,
    output logic [NLOOKUP-1:0]          lk_hit,
    output logic [NREG-1:0]             pending
);

    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_pending_nxt;

    // Set is applied after clear so a same-cycle reissue of the index survives.
    always_comb begin
        w_pending_nxt = r_pending;
        if (clr_en) begin
            w_pending_nxt[clr_idx] = 1'b0;
        end
        if (set_en) begin
            w_pending_nxt[set_idx] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NLOOKUP; gi++) begin : g_lookup
            assign lk_hit[gi] = lk_en[gi] && (lk_idx[gi] != '0) && r_pending[lk_idx[gi]];
        end
    endgenerate

    assign pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/gpr_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gpr_wb_arbiter
// Brief    : Merges ALU and long-op writebacks onto the GPR write port and
//            stalls decode on hazards against outstanding long ops.
// Revision : 1.0 - initial release
// ============================================================================
module gpr_wb_arbiter
    import gpr_wb_arbiter_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            dec_valid,
    input  logic            dec_long,
    input  logic            dec_rs1_en,
    input  logic            dec_rs2_en,
    input  logic [AW-1:0]   dec_rs1,
    input  logic [AW-1:0]   dec_rs2,
    input  logic [AW-1:0]   dec_rd,
    output logic            stall,
    input  logic            alu_wb_valid,
    input  logic [AW-1:0]   alu_wb_rd,
    input  logic [XLEN-1:0] alu_wb_data,
    input  logic            lsu_wb_valid,
    output logic            lsu_wb_ready,
    input  logic [AW-1:0]   lsu_wb_rd,
    input  logic [XLEN-1:0] lsu_wb_data,
    output logic            rf_wen,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [NREG-1:0] pending
);

    wb_req_t                   r_buf;
    wb_req_t                   w_alu_req;
    wb_req_t                   w_sel;
    logic [NLOOKUP-1:0]        w_hit;
    logic [NLOOKUP-1:0]        w_lk_en;
    logic [NLOOKUP-1:0][AW-1:0] w_lk_idx;
    logic                      w_issue;
    logic                      w_set_en;
    logic                      w_drain;
    logic                      w_lsu_accept;

    assign w_lk_en  = {1'b1, dec_rs2_en, dec_rs1_en};
    assign w_lk_idx = {dec_rd, dec_rs2, dec_rs1};

    assign stall    = reset && dec_valid && (|w_hit);
    assign w_issue  = dec_valid && !stall;
    assign w_set_en = w_issue && dec_long && (dec_rd != '0);

    // The buffer drains whenever the ALU leaves the port free.
    assign w_drain      = r_buf.valid && !alu_wb_valid;
    assign lsu_wb_ready = reset && (!r_buf.valid || !alu_wb_valid);
    assign w_lsu_accept = lsu_wb_valid && lsu_wb_ready;

    gpr_scoreboard u_scoreboard (
        .clock   (clock),
        .reset   (reset),
        .set_en  (w_set_en),
        .set_idx (dec_rd),
        .clr_en  (w_drain),
        .clr_idx (r_buf.rd),
        .lk_en   (w_lk_en),
        .lk_idx  (w_lk_idx),
        .lk_hit  (w_hit),
        .pending (pending)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_buf.valid <= 1'b0;
        end else if (w_lsu_accept) begin
            r_buf.valid <= 1'b1;
        end else if (w_drain) begin
            r_buf.valid <= 1'b0;
        end
        if (w_lsu_accept) begin
            r_buf.rd   <= lsu_wb_rd;
            r_buf.data <= lsu_wb_data;
        end
    end

    assign w_alu_req = '{valid: alu_wb_valid, rd: alu_wb_rd, data: alu_wb_data};

    always_comb begin
        w_sel = r_buf;
        if (alu_wb_valid) begin
            w_sel = w_alu_req;
        end
    end

    // x0 results still consume their slot but never reach the register file.
    assign rf_wen   = reset && w_sel.valid && (w_sel.rd != '0);
    assign rf_waddr = w_sel.rd;
    assign rf_wdata = w_sel.data;

endmodule
`default_nettype wire

// File: tb/tb_gpr_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpr_wb_arbiter
// Brief    : Directed vector bench for gpr_wb_arbiter and gpr_scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpr_wb_arbiter;
    import gpr_wb_arbiter_pkg::*;

    typedef struct {
        logic            dv, dl, r1e, r2e;
        logic [4:0]      rs1, rs2, rd;
        logic            av;
        logic [4:0]      ard;
        logic [63:0]     adata;
        logic            lv;
        logic [4:0]      lrd;
        logic [63:0]     ldata;
        logic            e_stall, e_ready, e_wen;
        logic [4:0]      e_waddr;
        logic [63:0]     e_wdata;
        logic [31:0]     e_pend;
    } vec_t;

    localparam int NV = 26;

    logic            clock = 1'b0;
    logic            reset;
    logic            dec_valid, dec_long, dec_rs1_en, dec_rs2_en;
    logic [AW-1:0]   dec_rs1, dec_rs2, dec_rd;
    logic            stall;
    logic            alu_wb_valid;
    logic [AW-1:0]   alu_wb_rd;
    logic [XLEN-1:0] alu_wb_data;
    logic            lsu_wb_valid;
    logic            lsu_wb_ready;
    logic [AW-1:0]   lsu_wb_rd;
    logic [XLEN-1:0] lsu_wb_data;
    logic            rf_wen;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [NREG-1:0] pending;

    logic                        sb_reset;
    logic                        sb_set_en, sb_clr_en;
    logic [AW-1:0]               sb_set_idx, sb_clr_idx;
    logic [NLOOKUP-1:0]          sb_lk_en;
    logic [NLOOKUP-1:0][AW-1:0]  sb_lk_idx;
    logic [NLOOKUP-1:0]          sb_lk_hit;
    logic [NREG-1:0]             sb_pending;

    int   n_pass  = 0;
    int   n_total = 0;
    vec_t vecs [NV];

    always #5 clock = ~clock;

    gpr_wb_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .dec_valid    (dec_valid),
        .dec_long     (dec_long),
        .dec_rs1_en   (dec_rs1_en),
        .dec_rs2_en   (dec_rs2_en),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_rd       (dec_rd),
        .stall        (stall),
        .alu_wb_valid (alu_wb_valid),
        .alu_wb_rd    (alu_wb_rd),
        .alu_wb_data  (alu_wb_data),
        .lsu_wb_valid (lsu_wb_valid),
        .lsu_wb_ready (lsu_wb_ready),
        .lsu_wb_rd    (lsu_wb_rd),
        .lsu_wb_data  (lsu_wb_data),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .pending      (pending)
    );

    gpr_scoreboard sb (
        .clock   (clock),
        .reset   (sb_reset),
        .set_en  (sb_set_en),
        .set_idx (sb_set_idx),
        .clr_en  (sb_clr_en),
        .clr_idx (sb_clr_idx),
        .lk_en   (sb_lk_en),
        .lk_idx  (sb_lk_idx),
        .lk_hit  (sb_lk_hit),
        .pending (sb_pending)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] bm(input int idx);
        return 32'(1) << idx;
    endfunction

    function automatic vec_t mk(
        input logic dv, input logic dl, input logic r1e, input logic [4:0] rs1,
        input logic r2e, input logic [4:0] rs2, input logic [4:0] rd,
        input logic av, input logic [4:0] ard, input logic [63:0] adata,
        input logic lv, input logic [4:0] lrd, input logic [63:0] ldata,
        input logic e_stall, input logic e_ready, input logic e_wen,
        input logic [4:0] e_waddr, input logic [63:0] e_wdata, input logic [31:0] e_pend);
        vec_t v;
        v.dv = dv; v.dl = dl; v.r1e = r1e; v.rs1 = rs1; v.r2e = r2e; v.rs2 = rs2; v.rd = rd;
        v.av = av; v.ard = ard; v.adata = adata;
        v.lv = lv; v.lrd = lrd; v.ldata = ldata;
        v.e_stall = e_stall; v.e_ready = e_ready; v.e_wen = e_wen;
        v.e_waddr = e_waddr; v.e_wdata = e_wdata; v.e_pend = e_pend;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        dec_valid = v.dv; dec_long = v.dl; dec_rs1_en = v.r1e; dec_rs2_en = v.r2e;
        dec_rs1 = v.rs1; dec_rs2 = v.rs2; dec_rd = v.rd;
        alu_wb_valid = v.av; alu_wb_rd = v.ard; alu_wb_data = v.adata;
        lsu_wb_valid = v.lv; lsu_wb_rd = v.lrd; lsu_wb_data = v.ldata;
    endtask

    task automatic idle();
        drive(mk(0,0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0));
    endtask

    // Interface invariants, only meaningful while out of reset
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            assert (!(alu_wb_valid && alu_wb_rd != '0 && pending[alu_wb_rd])) else begin
                n_total++; $display("FAIL inv_alu_pending: rd=%0d pending=0x%0h, required clear", alu_wb_rd, pending);
            end
            assert (!(lsu_wb_valid && lsu_wb_rd != '0 && !pending[lsu_wb_rd])) else begin
                n_total++; $display("FAIL inv_lsu_pending: rd=%0d pending=0x%0h, required set", lsu_wb_rd, pending);
            end
            assert (pending[0] == 1'b0) else begin
                n_total++; $display("FAIL inv_x0: pending[0]=1, required 0");
            end
        end
    end

    initial begin
        //                dv dl r1e rs1 r2e rs2 rd  av ard adata      lv lrd ldata       st rdy wen wa wdata        pend
        vecs[0]  = mk(1,1,0,0, 0,0,5,  0,0,0,          0,0,0,           0,1,0,0,0,             bm(5));
        vecs[1]  = mk(1,0,1,5, 0,0,6,  0,0,0,          0,0,0,           1,1,0,0,0,             bm(5));
        vecs[2]  = mk(1,0,1,5, 0,0,6,  0,0,0,          1,5,64'hDEAD,    1,1,0,0,0,             bm(5));
        vecs[3]  = mk(1,0,1,5, 0,0,6,  0,0,0,          0,0,0,           1,1,1,5,64'hDEAD,      0);
        vecs[4]  = mk(1,0,1,5, 0,0,6,  0,0,0,          0,0,0,           0,1,0,0,0,             0);
        vecs[5]  = mk(1,1,0,0, 0,0,7,  0,0,0,          0,0,0,           0,1,0,0,0,             bm(7));
        vecs[6]  = mk(0,0,0,0, 0,0,0,  1,1,64'h11,     1,7,64'h77,      0,1,1,1,64'h11,        bm(7));
        vecs[7]  = mk(0,0,0,0, 0,0,0,  1,2,64'h22,     0,0,0,           0,0,1,2,64'h22,        bm(7));
        vecs[8]  = mk(0,0,0,0, 0,0,0,  1,3,64'h33,     0,0,0,           0,0,1,3,64'h33,        bm(7));
        vecs[9]  = mk(0,0,0,0, 0,0,0,  0,0,0,          0,0,0,           0,1,1,7,64'h77,        0);
        vecs[10] = mk(1,1,0,0, 0,0,0,  0,0,0,          0,0,0,           0,1,0,0,0,             0);
        vecs[11] = mk(0,0,0,0, 0,0,0,  0,0,0,          1,0,64'hABC,     0,1,0,0,0,             0);
        vecs[12] = mk(1,0,1,0, 0,0,0,  0,0,0,          0,0,0,           0,1,0,0,0,             0);
        vecs[13] = mk(0,0,0,0, 0,0,0,  1,4,64'h44,     0,0,0,           0,1,1,4,64'h44,        0);
        vecs[14] = mk(1,1,0,0, 0,0,10, 0,0,0,          0,0,0,           0,1,0,0,0,             bm(10));
        vecs[15] = mk(1,1,0,0, 1,10,11,0,0,0,          0,0,0,           1,1,0,0,0,             bm(10));
        vecs[16] = mk(1,1,0,10,0,10,11,0,0,0,          0,0,0,           0,1,0,0,0,             bm(10)|bm(11));
        vecs[17] = mk(1,0,0,0, 0,0,11, 0,0,0,          1,10,64'hA0,     1,1,0,0,0,             bm(10)|bm(11));
        vecs[18] = mk(0,0,0,0, 0,0,0,  0,0,0,          1,11,64'hB1,     0,1,1,10,64'hA0,       bm(11));
        vecs[19] = mk(0,0,0,0, 0,0,0,  0,0,0,          0,0,0,           0,1,1,11,64'hB1,       0);
        vecs[20] = mk(1,1,0,0, 0,0,9,  0,0,0,          0,0,0,           0,1,0,0,0,             bm(9));
        vecs[21] = mk(0,0,0,0, 0,0,0,  1,14,64'hE,     1,9,64'h99,      0,1,1,14,64'hE,        bm(9));
        vecs[22] = mk(1,1,0,0, 0,0,9,  0,0,0,          0,0,0,           1,1,1,9,64'h99,        0);
        vecs[23] = mk(1,1,0,0, 0,0,9,  0,0,0,          0,0,0,           0,1,0,0,0,             bm(9));
        vecs[24] = mk(0,0,0,0, 0,0,0,  0,0,0,          1,9,64'h98,      0,1,0,0,0,             bm(9));
        vecs[25] = mk(0,0,0,0, 0,0,0,  0,0,0,          0,0,0,           0,1,1,9,64'h98,        0);

        sb_reset = 1'b0; sb_set_en = 1'b0; sb_clr_en = 1'b0;
        sb_set_idx = '0; sb_clr_idx = '0; sb_lk_en = '0; sb_lk_idx = '0;

        // Reset held with both sources asserting
        reset = 1'b0;
        drive(mk(1,0,1,3, 0,0,4, 1,1,64'h5, 1,2,64'h6, 0,0,0,0,0,0));
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #3;
            check($sformatf("rst%0d.wen", k),     64'(rf_wen), 64'd0);
            check($sformatf("rst%0d.ready", k),   64'(lsu_wb_ready), 64'd0);
            check($sformatf("rst%0d.stall", k),   64'(stall), 64'd0);
            check($sformatf("rst%0d.pending", k), 64'(pending), 64'd0);
        end
        reset = 1'b1;
        idle();
        @(posedge clock); #1;
        drive(mk(0,0,0,0, 0,0,0, 1,1,64'h1234, 0,0,0, 0,0,0,0,0,0));
        #3;
        check("rel.wen",     64'(rf_wen), 64'd1);
        check("rel.waddr",   64'(rf_waddr), 64'd1);
        check("rel.wdata",   rf_wdata, 64'h1234);
        check("rel.ready",   64'(lsu_wb_ready), 64'd1);
        check("rel.pending", 64'(pending), 64'd0);
        @(posedge clock); #1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            #3;
            check($sformatf("v%0d.stall", i), 64'(stall), 64'(vecs[i].e_stall));
            check($sformatf("v%0d.ready", i), 64'(lsu_wb_ready), 64'(vecs[i].e_ready));
            check($sformatf("v%0d.wen", i),   64'(rf_wen), 64'(vecs[i].e_wen));
            if (vecs[i].e_wen) begin
                check($sformatf("v%0d.waddr", i), 64'(rf_waddr), 64'(vecs[i].e_waddr));
                check($sformatf("v%0d.wdata", i), rf_wdata, vecs[i].e_wdata);
            end
            @(posedge clock); #1;
            check($sformatf("v%0d.pending", i), 64'(pending), 64'(vecs[i].e_pend));
        end

        // Reset pulse while a result sits in the buffer
        drive(mk(1,1,0,0, 0,0,12, 0,0,0, 0,0,0, 0,0,0,0,0,0));
        #3; check("mr.issue_stall", 64'(stall), 64'd0);
        @(posedge clock); #1;
        drive(mk(0,0,0,0, 0,0,0, 1,13,64'h13, 1,12,64'hC0FFEE, 0,0,0,0,0,0));
        #3;
        check("mr.accept_ready", 64'(lsu_wb_ready), 64'd1);
        check("mr.alu_waddr",    64'(rf_waddr), 64'd13);
        @(posedge clock); #1;
        reset = 1'b0;
        drive(mk(1,0,1,12, 0,0,15, 1,13,64'h13, 0,0,0, 0,0,0,0,0,0));
        #3;
        check("mr.rst_wen",   64'(rf_wen), 64'd0);
        check("mr.rst_ready", 64'(lsu_wb_ready), 64'd0);
        check("mr.rst_stall", 64'(stall), 64'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        drive(mk(1,0,1,12, 0,0,15, 0,0,0, 0,0,0, 0,0,0,0,0,0));
        #3;
        check("mr.post_wen",     64'(rf_wen), 64'd0);
        check("mr.post_pending", 64'(pending), 64'd0);
        check("mr.post_stall",   64'(stall), 64'd0);
        check("mr.post_ready",   64'(lsu_wb_ready), 64'd1);
        @(posedge clock); #1;
        idle();

        // Scoreboard: same-cycle set and clear of one index keeps it set
        sb_reset = 1'b1;
        sb_set_en = 1'b1; sb_set_idx = 5'd9;
        @(posedge clock); #1;
        sb_lk_en = 3'b111; sb_lk_idx = {5'd0, 5'd9, 5'd9};
        #1;
        check("sb.set",     64'(sb_pending), 64'(bm(9)));
        check("sb.lookups", 64'(sb_lk_hit), 64'd3);
        sb_clr_en = 1'b1; sb_clr_idx = 5'd9;
        @(posedge clock); #1;
        check("sb.set_wins", 64'(sb_pending), 64'(bm(9)));
        sb_set_en = 1'b0;
        @(posedge clock); #1;
        check("sb.clear", 64'(sb_pending), 64'd0);
        sb_clr_en = 1'b0; sb_set_en = 1'b1; sb_set_idx = 5'd0;
        @(posedge clock); #1;
        check("sb.x0", 64'(sb_pending), 64'd0);
        sb_set_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
